// File: rtl/rv_decode_pkg.sv
// Shared types and opcode constants for the RV32I instruction-type decoder.
package rv_decode_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic R;
    logic I;
    logic L;
    logic S;
    logic B;
    logic J;
    logic Jr;
    logic lui;
    logic aui;
    logic illegal;
  } inst_type_t;

  typedef struct packed {
    inst_type_t       typ;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
  } dec_word_t;

endpackage

// File: rtl/inst_type_decode_if.sv
// Fetch-side and decode-side handshake bundle of the instruction-type decoder.
interface inst_type_decode_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic            R, I, L, S, B, J, Jr, lui, aui;
  logic            illegal;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;

  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, R, I, L, S, B, J, Jr, lui, aui, illegal,
           rd, rs1, rs2, funct3, funct7, instr_out, pc_out
  );

  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, R, I, L, S, B, J, Jr, lui, aui, illegal,
           rd, rs1, rs2, funct3, funct7, instr_out, pc_out
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready, out_valid and payload all come from flops.
module pipe_skid_buf
  import rv_decode_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_state_t   state_r, state_s;
  logic [W-1:0] main_r, main_s;
  logic [W-1:0] skid_r, skid_s;
  logic         in_ready_r, out_valid_r;
  logic         accept_s, drain_s;

  // Occupancy next-state and data steering; flush overrides any accept.
  always_comb begin
    state_s  = state_r;
    main_s   = main_r;
    skid_s   = skid_r;
    accept_s = in_valid && in_ready_r;
    drain_s  = out_valid_r && out_ready;
    if (flush) begin
      state_s = OCC_EMPTY;
      main_s  = {W{1'b0}};
      skid_s  = {W{1'b0}};
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (accept_s) begin
            main_s  = in_data;
            state_s = OCC_ONE;
          end else begin
            state_s = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept_s && drain_s) begin
            main_s  = in_data;
            state_s = OCC_ONE;
          end else if (accept_s) begin
            skid_s  = in_data;
            state_s = OCC_TWO;
          end else if (drain_s) begin
            state_s = OCC_EMPTY;
          end else begin
            state_s = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (drain_s) begin
            main_s  = skid_r;
            state_s = OCC_ONE;
          end else begin
            state_s = OCC_TWO;
          end
        end
        default: begin
          state_s = OCC_EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= OCC_EMPTY;
      main_r      <= {W{1'b0}};
      skid_r      <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != OCC_TWO);
      out_valid_r <= (state_s != OCC_EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

endmodule

// File: rtl/inst_type_decode.sv
// RV32I opcode classifier and field extractor feeding a registered skid buffer.
module inst_type_decode
  import rv_decode_pkg::*;
(
  input logic              clk,
  input logic              rst,
  inst_type_decode_if.slave bus
);

  dec_word_t word_s;
  dec_word_t out_word_s;

  // Classify the incoming word; non-11 low bits can never be a 32-bit encoding.
  always_comb begin
    word_s        = '{default: 1'b0};
    word_s.rd     = bus.instr[11:7];
    word_s.rs1    = bus.instr[19:15];
    word_s.rs2    = bus.instr[24:20];
    word_s.funct3 = bus.instr[14:12];
    word_s.funct7 = bus.instr[31:25];
    word_s.instr  = bus.instr;
    word_s.pc     = bus.pc;
    if (bus.instr[1:0] != 2'b11) begin
      word_s.typ.illegal = 1'b1;
    end else begin
      case (bus.instr[6:0])
        OP_R:     word_s.typ.R       = 1'b1;
        OP_I:     word_s.typ.I       = 1'b1;
        OP_L:     word_s.typ.L       = 1'b1;
        OP_S:     word_s.typ.S       = 1'b1;
        OP_B:     word_s.typ.B       = 1'b1;
        OP_JAL:   word_s.typ.J       = 1'b1;
        OP_JALR:  word_s.typ.Jr      = 1'b1;
        OP_LUI:   word_s.typ.lui     = 1'b1;
        OP_AUIPC: word_s.typ.aui     = 1'b1;
        default:  word_s.typ.illegal = 1'b1;
      endcase
    end
  end

  pipe_skid_buf #(.W($bits(dec_word_t))) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (word_s),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_word_s)
  );

  assign bus.R         = out_word_s.typ.R;
  assign bus.I         = out_word_s.typ.I;
  assign bus.L         = out_word_s.typ.L;
  assign bus.S         = out_word_s.typ.S;
  assign bus.B         = out_word_s.typ.B;
  assign bus.J         = out_word_s.typ.J;
  assign bus.Jr        = out_word_s.typ.Jr;
  assign bus.lui       = out_word_s.typ.lui;
  assign bus.aui       = out_word_s.typ.aui;
  assign bus.illegal   = out_word_s.typ.illegal;
  assign bus.rd        = out_word_s.rd;
  assign bus.rs1       = out_word_s.rs1;
  assign bus.rs2       = out_word_s.rs2;
  assign bus.funct3    = out_word_s.funct3;
  assign bus.funct7    = out_word_s.funct7;
  assign bus.instr_out = out_word_s.instr;
  assign bus.pc_out    = out_word_s.pc;

endmodule

// File: tb/tb_inst_type_decode.sv
// Directed self-checking bench for inst_type_decode.
module tb_inst_type_decode;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  inst_type_decode_if #(.XLEN(32)) bus ();

  inst_type_decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: R I L S B J Jr lui aui illegal
  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_R    = 10'b1000000000;
  localparam logic [9:0] F_I    = 10'b0100000000;
  localparam logic [9:0] F_S    = 10'b0001000000;
  localparam logic [9:0] F_B    = 10'b0000100000;
  localparam logic [9:0] F_JR   = 10'b0000001000;
  localparam logic [9:0] F_LUI  = 10'b0000000100;
  localparam logic [9:0] F_ILL  = 10'b0000000001;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_LUI  = 32'h123452B7;
  localparam logic [31:0] W_JALR = 32'h000100E7;
  localparam logic [31:0] W_ADDI = 32'h00500093;
  localparam logic [31:0] W_SW   = 32'h0020A223;
  localparam logic [31:0] W_BEQ  = 32'h00208463;

  function automatic logic [9:0] flags();
    return {bus.R, bus.I, bus.L, bus.S, bus.B, bus.J, bus.Jr, bus.lui, bus.aui, bus.illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.instr = 32'h0; bus.pc = 32'h0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (flags() !== F_NONE) begin n_bad++; $display("FAIL reset_flags: got %b expected %b", flags(), F_NONE); end
    n_cmp++; if ({bus.rd, bus.instr_out, bus.pc_out} !== 69'h0) begin n_bad++; $display("FAIL reset_fields: got rd=%0d instr=%h pc=%h expected zero", bus.rd, bus.instr_out, bus.pc_out); end
  endtask

  task automatic test_add();
    bus.in_valid = 1'b1; bus.instr = W_ADD; bus.pc = 32'h00000100;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b expected 1", bus.out_valid); end
    n_cmp++; if (flags() !== F_R) begin n_bad++; $display("FAIL add_flags: got %b expected %b", flags(), F_R); end
    n_cmp++; if ({bus.rd, bus.rs1, bus.rs2, bus.funct3} !== {5'd3, 5'd1, 5'd2, 3'd0}) begin
      n_bad++; $display("FAIL add_fields: got rd=%0d rs1=%0d rs2=%0d f3=%0d expected 3 1 2 0", bus.rd, bus.rs1, bus.rs2, bus.funct3); end
    n_cmp++; if (bus.pc_out !== 32'h00000100) begin n_bad++; $display("FAIL add_pc: got %h expected 00000100", bus.pc_out); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL add_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.instr = W_LUI; bus.pc = 32'h00000200;
    step();
    n_cmp++; if (flags() !== F_LUI || bus.rd !== 5'd5 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_lui: got flags=%b rd=%0d v=%b expected %b rd=5 v=1", flags(), bus.rd, bus.out_valid, F_LUI); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b expected 1", bus.in_ready); end
    bus.instr = W_JALR; bus.pc = 32'h00000204;
    step();
    n_cmp++; if (flags() !== F_JR || bus.rd !== 5'd1 || bus.rs1 !== 5'd2) begin
      n_bad++; $display("FAIL b2b_jalr: got flags=%b rd=%0d rs1=%0d expected %b rd=1 rs1=2", flags(), bus.rd, bus.rs1, F_JR); end
    bus.instr = 32'h00000000; bus.pc = 32'h00000208;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (flags() !== F_ILL || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_illegal: got flags=%b v=%b expected %b v=1", flags(), bus.out_valid, F_ILL); end
    n_cmp++; if (bus.pc_out !== 32'h00000208) begin n_bad++; $display("FAIL b2b_pc: got %h expected 00000208", bus.pc_out); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr = W_ADDI; bus.pc = 32'h00000300;
    step();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_one_ready: got %b expected 1", bus.in_ready); end
    bus.instr = W_SW; bus.pc = 32'h00000304;
    step();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_two_ready: got %b expected 0", bus.in_ready); end
    n_cmp++; if (flags() !== F_I || bus.instr_out !== W_ADDI) begin
      n_bad++; $display("FAIL stall_head: got flags=%b instr=%h expected %b %h", flags(), bus.instr_out, F_I, W_ADDI); end
    bus.instr = W_BEQ; bus.pc = 32'h00000308;
    step();
    n_cmp++; if (bus.instr_out !== W_ADDI || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stall_hold: got instr=%h rdy=%b v=%b expected %h 0 1", bus.instr_out, bus.in_ready, bus.out_valid, W_ADDI); end
    bus.out_ready = 1'b1;
    step();
    n_cmp++; if (flags() !== F_S || bus.instr_out !== W_SW || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_drain1: got flags=%b instr=%h rdy=%b expected %b %h 1", flags(), bus.instr_out, bus.in_ready, F_S, W_SW); end
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (flags() !== F_B || bus.instr_out !== W_BEQ || bus.pc_out !== 32'h00000308) begin
      n_bad++; $display("FAIL stall_drain2: got flags=%b instr=%h pc=%h expected %b %h 00000308", flags(), bus.instr_out, bus.pc_out, F_B, W_BEQ); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr = W_ADD; bus.pc = 32'h00000400;
    step();
    bus.instr = W_SW;
    step();
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre_two: got %b expected 0", bus.in_ready); end
    bus.instr = W_BEQ; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL flush_state: got v=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_quiet%0d: got %b expected 0", k, bus.out_valid); end
    end
    bus.in_valid = 1'b1; bus.instr = W_LUI; bus.pc = 32'h00000410;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.instr_out !== W_LUI || flags() !== F_LUI) begin
      n_bad++; $display("FAIL flush_resume: got instr=%h flags=%b expected %h %b", bus.instr_out, flags(), W_LUI, F_LUI); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.instr = W_JALR; bus.pc = 32'h00000500;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_one: got %b expected 1", bus.out_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || flags() !== F_NONE) begin
      n_bad++; $display("FAIL rstmid_clear: got v=%b rdy=%b flags=%b expected 0 1 %b", bus.out_valid, bus.in_ready, flags(), F_NONE); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.instr = W_ADDI; bus.pc = 32'h00000510;
    step();
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.instr_out !== W_ADDI || flags() !== F_I || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_first: got instr=%h flags=%b v=%b expected %h %b 1", bus.instr_out, flags(), bus.out_valid, W_ADDI, F_I); end
    step();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_end: got %b expected 0", bus.out_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
